// File: rtl/present_sbox_layer_ctrl.sv
// Sequencer that streams a 3-share PRESENT state through a LATENCY-deep masked S-box core.
// Optional build macro PRESENT_SB_PRECHARGE_EN: zero the sb_in shares whenever sb_in_valid is low.
module present_sbox_layer_ctrl #(
    parameter int unsigned LATENCY = 5,
    parameter int unsigned NIB     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NIB-1:0]  state_in_s1,
    input  logic [4*NIB-1:0]  state_in_s2,
    input  logic [4*NIB-1:0]  state_in_s3,
    output logic [3:0]        sb_in_s1,
    output logic [3:0]        sb_in_s2,
    output logic [3:0]        sb_in_s3,
    output logic              sb_in_valid,
    input  logic [3:0]        sb_out_s1,
    input  logic [3:0]        sb_out_s2,
    input  logic [3:0]        sb_out_s3,
    output logic [4*NIB-1:0]  state_out_s1,
    output logic [4*NIB-1:0]  state_out_s2,
    output logic [4*NIB-1:0]  state_out_s3,
    output logic              busy,
    output logic              done
);

    localparam int unsigned W  = 4 * NIB;
    localparam int unsigned CW = $clog2(NIB);
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_e;

    state_e              state_q;
    logic [W-1:0]        sh1_q, sh2_q, sh3_q;
    logic [W-1:0]        out1_q, out2_q, out3_q;
    logic [3:0]          sb1_q, sb2_q, sb3_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;
    logic [CW-1:0]       feed_cnt_q;
    logic [CW-1:0]       cap_cnt_q;
    logic [LATENCY-1:0]  vsr_q;

    logic [CW-1:0]       feed_cnt_d;
    logic [CW+1:0]       feed_base_d;
    logic [CW+1:0]       cap_base;
    logic                tap;

    always_comb begin
        feed_cnt_d  = feed_cnt_q + 1'b1;
        feed_base_d = {feed_cnt_d, 2'b00};
        cap_base    = {cap_cnt_q, 2'b00};
        tap         = vsr_q[LATENCY-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sh1_q      <= '0;
            sh2_q      <= '0;
            sh3_q      <= '0;
            out1_q     <= '0;
            out2_q     <= '0;
            out3_q     <= '0;
            sb1_q      <= '0;
            sb2_q      <= '0;
            sb3_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            feed_cnt_q <= '0;
            cap_cnt_q  <= '0;
            vsr_q      <= '0;
        end else begin
            // vsr_q[k] set means a nibble entered the core k+1 cycles ago
            vsr_q[0] <= valid_q;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                vsr_q[i] <= vsr_q[i-1];
            end

            if (tap) begin
                out1_q[cap_base +: 4] <= sb_out_s1;
                out2_q[cap_base +: 4] <= sb_out_s2;
                out3_q[cap_base +: 4] <= sb_out_s3;
                cap_cnt_q             <= cap_cnt_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        sh1_q      <= state_in_s1;
                        sh2_q      <= state_in_s2;
                        sh3_q      <= state_in_s3;
                        sb1_q      <= state_in_s1[3:0];
                        sb2_q      <= state_in_s2[3:0];
                        sb3_q      <= state_in_s3[3:0];
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        feed_cnt_q <= '0;
                        cap_cnt_q  <= '0;
                        state_q    <= FEED;
                    end
                end
                FEED: begin
                    // feed_cnt_q is the nibble currently presented on sb_in
                    if (feed_cnt_q == LAST) begin
                        valid_q <= 1'b0;
`ifdef PRESENT_SB_PRECHARGE_EN
                        sb1_q   <= '0;
                        sb2_q   <= '0;
                        sb3_q   <= '0;
`endif
                        state_q <= DRAIN;
                    end else begin
                        feed_cnt_q <= feed_cnt_d;
                        sb1_q      <= sh1_q[feed_base_d +: 4];
                        sb2_q      <= sh2_q[feed_base_d +: 4];
                        sb3_q      <= sh3_q[feed_base_d +: 4];
                    end
                end
                DRAIN: begin
                    if (tap && (cap_cnt_q == LAST)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sb_in_s1     = sb1_q;
    assign sb_in_s2     = sb2_q;
    assign sb_in_s3     = sb3_q;
    assign sb_in_valid  = valid_q;
    assign state_out_s1 = out1_q;
    assign state_out_s2 = out2_q;
    assign state_out_s3 = out3_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_present_sbox_layer_ctrl.sv
// Scoreboard bench for present_sbox_layer_ctrl with a re-masking reference S-box core model.
module tb_present_sbox_layer_ctrl;

    localparam int unsigned LAT = 5;
    localparam logic [63:0] PT   = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT   = 64'hC56B90AD3EF84712;
    localparam logic [63:0] CT0  = 64'hCCCCCCCCCCCCCCCC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] state_in_s1, state_in_s2, state_in_s3;
    logic [3:0]  sb_in_s1, sb_in_s2, sb_in_s3;
    logic        sb_in_valid;
    logic [3:0]  sb_out_s1, sb_out_s2, sb_out_s3;
    logic [63:0] state_out_s1, state_out_s2, state_out_s3;
    logic        busy, done;

    always #5 clk = ~clk;

    present_sbox_layer_ctrl #(.LATENCY(LAT), .NIB(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .state_in_s1  (state_in_s1),
        .state_in_s2  (state_in_s2),
        .state_in_s3  (state_in_s3),
        .sb_in_s1     (sb_in_s1),
        .sb_in_s2     (sb_in_s2),
        .sb_in_s3     (sb_in_s3),
        .sb_in_valid  (sb_in_valid),
        .sb_out_s1    (sb_out_s1),
        .sb_out_s2    (sb_out_s2),
        .sb_out_s3    (sb_out_s3),
        .state_out_s1 (state_out_s1),
        .state_out_s2 (state_out_s2),
        .state_out_s3 (state_out_s3),
        .busy         (busy),
        .done         (done)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          done_cyc;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference core: unshared PRESENT S-box on the recombined nibble, re-split with fresh masks
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] t;
        int          idx;
        t   = CT;
        idx = 60 - 4 * int'(x);
        return t[idx +: 4];
    endfunction

    logic [11:0] pipe [LAT];
    logic [3:0]  m_r2, m_r3, m_y;
    logic [11:0] m_e;

    always @(posedge clk) begin
        m_r2 = 4'($urandom);
        m_r3 = 4'($urandom);
        if (sb_in_valid) begin
            m_y = sbox(sb_in_s1 ^ sb_in_s2 ^ sb_in_s3);
            m_e = {m_y ^ m_r2 ^ m_r3, m_r2, m_r3};
        end else begin
            m_e = 12'($urandom);
        end
        pipe[0] <= m_e;
        for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end

    assign sb_out_s1 = pipe[LAT-1][11:8];
    assign sb_out_s2 = pipe[LAT-1][7:4];
    assign sb_out_s3 = pipe[LAT-1][3:0];

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                chk("done_unexpected", 256'(done), 256'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", 256'(state_out_s1 ^ state_out_s2 ^ state_out_s3), 256'(e.res));
                chk("done_cycle", 256'(cyc), 256'(e.done_cyc));
                chk("busy_at_done", 256'(busy), 256'(0));
            end
        end
    end

    task automatic chk_zero(input string name);
        chk(name, 256'({sb_in_s1, sb_in_s2, sb_in_s3, sb_in_valid, busy, done,
                        state_out_s1, state_out_s2, state_out_s3}), 256'(0));
    endtask

    // Issues one run; cycle k of the run is sampled at the k-th negedge after start.
    task automatic run(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [63:0] exp, input bit glitch, input int abort_at);
        int          n0;
        exp_t        e;
        logic [11:0] idle_sb;
        @(negedge clk);
        start       = 1'b1;
        state_in_s1 = a;
        state_in_s2 = b;
        state_in_s3 = c;
        n0          = cyc;
        if (abort_at == 0) begin
            e.res      = exp;
            e.done_cyc = n0 + 17 + int'(LAT);
            sb_q.push_back(e);
        end
`ifdef PRESENT_SB_PRECHARGE_EN
        idle_sb = 12'h000;
`else
        idle_sb = {a[63:60], b[63:60], c[63:60]};
`endif
        for (int k = 1; k <= 17 + int'(LAT); k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk_zero("reset_midrun");
                rst_n = 1'b1;
                return;
            end
            if (glitch && (k == 5 || k == 20 || k == 17 + int'(LAT))) begin
                start       = 1'b1;
                state_in_s1 = {$urandom, $urandom};
                state_in_s2 = {$urandom, $urandom};
                state_in_s3 = {$urandom, $urandom};
            end
            if (k <= 16) begin
                chk("feed", 256'({sb_in_valid, busy, sb_in_s1, sb_in_s2, sb_in_s3}),
                    256'({1'b1, 1'b1, a[4*(k-1) +: 4], b[4*(k-1) +: 4], c[4*(k-1) +: 4]}));
            end else begin
                chk("idle_sb", 256'({sb_in_valid, sb_in_s1, sb_in_s2, sb_in_s3}),
                    256'({1'b0, idle_sb}));
                chk("busy_drain", 256'(busy), 256'(k < 17 + int'(LAT)));
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [63:0] m2, m3;
        rst_n       = 1'b0;
        start       = 1'b0;
        state_in_s1 = '0;
        state_in_s2 = '0;
        state_in_s3 = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset_outputs");
        start       = 1'b1;
        state_in_s1 = PT;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("busy_in_reset", 256'(busy), 256'(0));
        chk_zero("reset_hold");
        rst_n = 1'b1;

        run(PT, 64'h0, 64'h0, CT, 1'b0, 0);

        for (int r = 0; r < 1000; r++) begin
            m2 = {$urandom, $urandom};
            m3 = {$urandom, $urandom};
            run(PT ^ m2 ^ m3, m2, m3, CT, 1'b0, 0);
        end

        m2 = {$urandom, $urandom};
        m3 = {$urandom, $urandom};
        run(PT ^ m2 ^ m3, m2, m3, CT, 1'b1, 0);
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", 256'(busy), 256'(0));
        repeat (LAT + 20) @(negedge clk);
        chk("idle_after_glitch", 256'({busy, sb_in_valid}), 256'(0));

        m2 = {$urandom, $urandom};
        m3 = {$urandom, $urandom};
        run(PT ^ m2 ^ m3, m2, m3, CT, 1'b0, 10);
        run(64'h0, 64'h0, 64'h0, CT0, 1'b0, 0);
        m2 = {$urandom, $urandom};
        m3 = {$urandom, $urandom};
        run(m2 ^ m3, m2, m3, CT0, 1'b0, 0);

        repeat (LAT + 5) @(negedge clk);
        chk("scoreboard_empty", 256'(sb_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/present_sbox_layer_ctrl.md
# present_sbox_layer_ctrl

Sequencer for the 3-share masked PRESENT S-box layer. It loads a 64-bit, 3-share cipher state and streams its 16 nibbles, one per cycle, into the external LATENCY-stage masked S-box core. It captures the core's shared outputs back into place and signals completion. It sits between the round-state register and the shared S-box pipeline (input affine, quadratic, middle affine, quadratic, output affine).

## Interface
- LATENCY, 5: fixed pipeline depth of the S-box core, in cycles from sb_in to sb_out; legal 1..8.
- NIB, 16: nibbles per state; fixed, state width 4*NIB.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; sampled only in IDLE.
- state_in_s1/s2/s3  in  64 each  input state shares, sampled at start.
- sb_in_s1/s2/s3  out  4 each  nibble shares to the S-box core.
- sb_in_valid  out  1  sb_in carries a live nibble.
- sb_out_s1/s2/s3  in  4 each  core output shares; valid exactly LATENCY cycles after the matching sb_in.
- state_out_s1/s2/s3  out  64 each  result shares; stable from done until the next start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, FEED, DRAIN, DONE. All state is registered.
- IDLE, start=1: latch the three input shares into the internal state registers, clear feed_cnt and cap_cnt, go to FEED. Writes to state_out are blocked until the first capture.
- FEED: drive nibble feed_cnt, bits [4i+3:4i] of each share, with sb_in_valid=1. feed_cnt counts 0..15, so nibble 0 goes first. After feed_cnt=15, go to DRAIN.
- A LATENCY-deep valid shift register tracks in-flight nibbles. When its tap is 1, write sb_out_s* into nibble cap_cnt of state_out_s*, then increment cap_cnt.
- DRAIN: sb_in_valid=0. When the 16th capture occurs (cap_cnt=15 with tap=1), go to DONE.
- DONE: done=1 and busy=0 for one cycle, then return to IDLE.
- Shares are never recombined inside the block. Each share travels on its own path, and no logic mixes s1/s2/s3.
- start while not in IDLE is ignored and does not queue.
- sb_out values without a valid tap are never written.
- Counters are 4-bit and never wrap mid-run; FSM transitions occur at count 15.
- Reset, including mid-run: FSM goes to IDLE, counters and the valid shift register clear, and in-flight results are discarded.
- Reset value of every output is 0: sb_in_s*, sb_in_valid, state_out_s*, busy, done.

## Timing
- Cycle 0: start sampled.
- Cycles 1..16: sb_in_valid=1, carrying nibble k-1 in cycle k.
- Nibble k-1 result is present on sb_out in cycle k+LATENCY and captured at the end of that cycle.
- Last capture: end of cycle 16+LATENCY.
- done=1 in cycle 17+LATENCY, which is cycle 22 for LATENCY=5.
- busy=1 in cycles 1..16+LATENCY.
- Throughput: one nibble per cycle. Minimum start-to-start interval: 18+LATENCY cycles.

## Configuration
- PRESENT_SB_PRECHARGE_EN defined: sb_in_s1/s2/s3 are forced to 0 in every cycle with sb_in_valid=0. This precharges the core's input registers between runs and avoids share transitions that leak Hamming distance.
- Not defined: sb_in_s* hold the last driven nibble while sb_in_valid=0. This saves the 12 AND gates.
- Cycle timing is identical in both builds.

## Test plan
Bench: reference core model = unshared PRESENT S-box applied to recombined shares, re-split with fresh random shares, LATENCY-cycle delay.
- Reset: rst_n low, then observe all outputs -> all 0. Pulse start with rst_n held low -> busy stays 0.
- Unmasked vector: state_in_s1=0x0123456789ABCDEF, s2=s3=0, start -> done at cycle 22; s1^s2^s3 = 0xC56B90AD3EF84712.
- Random masks: the same secret split with random s2, s3 over 1000 runs -> recombined output always 0xC56B90AD3EF84712. Each sb_in_s* equals the matching input share nibble exactly.
- start pulsed in cycles 5 and 20 of a run -> ignored; exactly one done; next start accepted only in IDLE.
- Reset asserted in cycle 10 -> outputs 0 next cycle. The following run with state 0 gives recombined 0xCCCCCCCCCCCCCCCC and no stale captures.
- Precharge: with PRESENT_SB_PRECHARGE_EN, sb_in_s*=0 in cycles 17..22. Without it, they hold nibble 15 of the input shares.
